fifo_count_checker: RTL and testbench

FIFO_COUNT_CHECKER -- requirements
Module: fifo_count_checker

---
 rtl/fifo_count_checker.sv | 181 ++++++++++++++++++
 tb/tb_fifo_count_checker.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_count_checker.sv
// rtl/fifo_count_checker.sv - PC-to-FPGA FIFO counting-pattern checker; optional mismatch capture via FIFO_COUNT_CHECKER_CAPTURE_EN
module fifo_count_checker #(
   parameter logic [12:0] BASE_ADDR = 13'd16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pio_write_valid,
   input  logic [63:0] pio_write_data,
   input  logic [12:0] pio_address,
   input  logic [63:0] fpc_data,
   input  logic        fpc_valid,
   output logic        fpc_read,
   output logic        locked,
   output logic [31:0] word_count,
   output logic [31:0] error_count,
   output logic [63:0] bad_expected,
   output logic [63:0] bad_received
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_resync;
   logic [3:0]  r_throttle;
   logic [3:0]  r_thr_cnt;
   logic [3:0]  w_thr_nxt;
   logic        r_fpc_read;
   logic        w_read_nxt;
   logic        w_restart;
   logic [63:0] r_expected;
   logic [31:0] r_word_count;
   logic [31:0] r_error_count;

   logic        w_ctrl_wr;
   logic        w_thr_wr;
   logic        w_clear;
   logic        w_xfer;
   logic        w_match;
   logic        w_mismatch;
   logic        w_unused;

   // Register decode: control at BASE_ADDR, throttle at BASE_ADDR+1, all else ignored.
   assign w_ctrl_wr  = pio_write_valid && (pio_address == BASE_ADDR);
   assign w_thr_wr   = pio_write_valid && (pio_address == (BASE_ADDR + 13'd1));
   assign w_clear    = w_ctrl_wr && pio_write_data[1];

   // A word is consumed only when our registered read meets a valid word.
   assign w_xfer     = r_fpc_read && fpc_valid;
   assign w_match    = (fpc_data == r_expected);
   assign w_mismatch = w_xfer && !w_clear && (r_state == ST_CHECK) && !w_match;

   // Only the low control/throttle bits carry meaning.
   assign w_unused   = &{1'b0, pio_write_data[63:4]};

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, throttle phase and next read request; a control write outranks the stream.
   always_comb begin
      w_state_nxt = r_state;
      w_restart   = 1'b0;
      w_thr_nxt   = r_thr_cnt;
      w_read_nxt  = 1'b0;

      case (r_state)
         ST_SYNC: begin
            if (w_xfer) begin
               w_state_nxt = ST_CHECK;
            end
         end
         default: begin
         end
      endcase

      if (w_ctrl_wr) begin
         if (!pio_write_data[0]) begin
            w_state_nxt = ST_IDLE;
         end else if (w_clear || (r_state == ST_IDLE)) begin
            w_state_nxt = ST_SYNC;
         end
      end

      // Re-entering SYNC or rewriting the throttle realigns the read cadence.
      w_restart = w_thr_wr ||
                  ((w_state_nxt == ST_SYNC) && ((r_state != ST_SYNC) || w_clear));

      if (w_restart) begin
         w_thr_nxt = 4'd0;
      end else if (w_state_nxt != ST_IDLE) begin
         w_thr_nxt = (r_thr_cnt >= r_throttle) ? 4'd0 : (r_thr_cnt + 4'd1);
      end

      w_read_nxt = (w_state_nxt != ST_IDLE) && (w_thr_nxt == 4'd0);
   end

   // Register file, read request, expected word and counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_resync      <= 1'b0;
         r_throttle    <= 4'd0;
         r_thr_cnt     <= 4'd0;
         r_fpc_read    <= 1'b0;
         r_expected    <= 64'd0;
         r_word_count  <= 32'd0;
         r_error_count <= 32'd0;
      end else begin
         r_fpc_read <= w_read_nxt;
         r_thr_cnt  <= w_thr_nxt;

         if (w_ctrl_wr) begin
            r_resync <= pio_write_data[2];
         end
         if (w_thr_wr) begin
            r_throttle <= pio_write_data[3:0];
         end

         if (w_clear) begin
            // A transfer landing on the clear cycle is dropped uncounted.
            r_word_count  <= 32'd0;
            r_error_count <= 32'd0;
         end else if (w_xfer && (r_state != ST_IDLE)) begin
            r_word_count <= r_word_count + 32'd1;
            if ((r_state == ST_SYNC) || w_match) begin
               r_expected <= fpc_data + 64'd1;
            end else begin
               if (r_error_count != 32'hFFFF_FFFF) begin
                  r_error_count <= r_error_count + 32'd1;
               end
               r_expected <= r_resync ? (fpc_data + 64'd1) : (r_expected + 64'd1);
            end
         end
      end
   end

`ifdef FIFO_COUNT_CHECKER_CAPTURE_EN
   logic        r_cap_valid;
   logic [63:0] r_bad_expected;
   logic [63:0] r_bad_received;

   // Latch the first mismatch after clear/reset; values persist until overwritten by a later first mismatch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cap_valid    <= 1'b0;
         r_bad_expected <= 64'd0;
         r_bad_received <= 64'd0;
      end else if (w_clear) begin
         r_cap_valid <= 1'b0;
      end else if (w_mismatch && !r_cap_valid) begin
         r_cap_valid    <= 1'b1;
         r_bad_expected <= r_expected;
         r_bad_received <= fpc_data;
      end
   end

   assign bad_expected = r_bad_expected;
   assign bad_received = r_bad_received;
`else
   logic w_unused_capture;
   assign w_unused_capture = w_mismatch;
   assign bad_expected     = 64'd0;
   assign bad_received     = 64'd0;
`endif

   assign fpc_read    = r_fpc_read;
   assign locked      = (r_state == ST_CHECK);
   assign word_count  = r_word_count;
   assign error_count = r_error_count;

endmodule

// File: tb/tb_fifo_count_checker.sv
// tb/tb_fifo_count_checker.sv - randomized and directed bench for fifo_count_checker against a behavioural model
module tb_fifo_count_checker;

   localparam logic [12:0] BASE = 13'd16;
`ifdef FIFO_COUNT_CHECKER_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        pio_write_valid;
   logic [63:0] pio_write_data;
   logic [12:0] pio_address;
   logic [63:0] fpc_data;
   logic        fpc_valid;
   logic        fpc_read;
   logic        locked;
   logic [31:0] word_count;
   logic [31:0] error_count;
   logic [63:0] bad_expected;
   logic [63:0] bad_received;

   always #5 clock = ~clock;

   fifo_count_checker #(.BASE_ADDR(BASE)) dut (
      .clock           (clock),
      .reset           (reset),
      .pio_write_valid (pio_write_valid),
      .pio_write_data  (pio_write_data),
      .pio_address     (pio_address),
      .fpc_data        (fpc_data),
      .fpc_valid       (fpc_valid),
      .fpc_read        (fpc_read),
      .locked          (locked),
      .word_count      (word_count),
      .error_count     (error_count),
      .bad_expected    (bad_expected),
      .bad_received    (bad_received)
   );

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   logic        m_en, m_locked, m_resync, m_cap, m_read, m_xfer;
   logic [3:0]  m_n;
   int          m_phase;
   logic [63:0] m_exp, m_be, m_br;
   logic [31:0] m_wc, m_ec;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_locked = 1'b0; m_resync = 1'b0; m_cap = 1'b0;
      m_read = 1'b0; m_xfer = 1'b0; m_n = 4'd0; m_phase = 0;
      m_exp = 64'd0; m_be = 64'd0; m_br = 64'd0; m_wc = 32'd0; m_ec = 32'd0;
   endtask

   task automatic model_step(input logic wv, input logic [12:0] wa, input logic [63:0] wd,
                             input logic fv, input logic [63:0] fd);
      logic ctrl, thr, clr, restart;
      ctrl = wv && (wa == BASE);
      thr  = wv && (wa == BASE + 13'd1);
      clr  = ctrl && wd[1];
      m_xfer = m_read && fv;
      if (m_xfer && !clr) begin
         m_wc = m_wc + 32'd1;
         if (!m_locked) begin
            m_exp = fd + 64'd1;
            m_locked = 1'b1;
         end else if (fd == m_exp) begin
            m_exp = m_exp + 64'd1;
         end else begin
            if (m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 32'd1;
            if (!m_cap) begin
               m_cap = 1'b1; m_be = m_exp; m_br = fd;
            end
            m_exp = m_resync ? fd + 64'd1 : m_exp + 64'd1;
         end
      end
      restart = thr;
      if (ctrl) begin
         if (!wd[0]) begin
            m_en = 1'b0; m_locked = 1'b0;
         end else if (clr || !m_en) begin
            m_en = 1'b1; m_locked = 1'b0; restart = 1'b1;
         end
         m_resync = wd[2];
         if (clr) begin
            m_wc = 32'd0; m_ec = 32'd0; m_cap = 1'b0;
         end
      end
      if (thr) m_n = wd[3:0];
      if (restart) m_phase = 0;
      else if (m_en) m_phase = (m_phase + 1) % (int'(m_n) + 1);
      m_read = m_en && (m_phase == 0);
   endtask

   task automatic compare_all();
      check("fpc_read",     64'(fpc_read),    64'(m_read));
      check("locked",       64'(locked),      64'(m_locked));
      check("word_count",   64'(word_count),  64'(m_wc));
      check("error_count",  64'(error_count), 64'(m_ec));
      check("bad_expected", bad_expected,     CAP ? m_be : 64'd0);
      check("bad_received", bad_received,     CAP ? m_br : 64'd0);
   endtask

   // one clock: drive at the falling edge, step the model, compare at the next falling edge
   task automatic cycle(input logic wv, input logic [12:0] wa, input logic [63:0] wd,
                        input logic fv, input logic [63:0] fd);
      pio_write_valid = wv; pio_address = wa; pio_write_data = wd;
      fpc_valid = fv; fpc_data = fd;
      model_step(wv, wa, wd, fv, fd);
      @(posedge clock);
      @(negedge clock);
      compare_all();
   endtask

   task automatic feed(input logic [63:0] words[$], output int ncyc);
      int idx;
      idx = 0;
      ncyc = 0;
      while (idx < words.size() && ncyc < 2000) begin
         cycle(1'b0, 13'd0, 64'd0, 1'b1, words[idx]);
         ncyc++;
         if (m_xfer) idx++;
      end
      if (idx < words.size()) check("feed_timeout", 64'(idx), 64'(words.size()));
   endtask

   logic [63:0] q[$];
   int          nc;
   int          rd_cnt;
   logic [63:0] dval;

   initial begin
      reset = 1'b1;
      pio_write_valid = 1'b0; pio_address = 13'd0; pio_write_data = 64'd0;
      fpc_valid = 1'b0; fpc_data = 64'd0;
      model_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      compare_all();
      reset = 1'b0;
      cycle(1'b0, 13'd0, 64'd0, 1'b1, 64'd9);
      check("idle_read", 64'(fpc_read), 64'd0);

      // continuous stream 100..199, N=0
      cycle(1'b1, BASE, 64'h1, 1'b0, 64'd0);
      check("en_read", 64'(fpc_read), 64'd1);
      q.delete(); q.push_back(64'd100);
      feed(q, nc);
      check("locked_first", 64'(locked), 64'd1);
      check("seed_cycles", 64'(nc), 64'd1);
      q.delete();
      for (int i = 101; i < 200; i++) q.push_back(64'(i));
      feed(q, nc);
      check("r33_cycles", 64'(nc), 64'd99);
      check("r33_wc", 64'(word_count), 64'd100);
      check("r33_ec", 64'(error_count), 64'd0);

      // one glitch, no resync
      cycle(1'b1, BASE, 64'h3, 1'b0, 64'd0);
      q = '{64'd0, 64'd1, 64'd2, 64'd7, 64'd4, 64'd5};
      feed(q, nc);
      check("r34_ec", 64'(error_count), 64'd1);
      check("r34_wc", 64'(word_count), 64'd6);
      check("r34_bexp", bad_expected, CAP ? 64'd3 : 64'd0);
      check("r34_brcv", bad_received, CAP ? 64'd7 : 64'd0);

      // same stream with resync: 7 mismatches (reseeds 8), 4 mismatches (reseeds 5), 5 matches
      cycle(1'b1, BASE, 64'h7, 1'b0, 64'd0);
      feed(q, nc);
      check("r35_ec", 64'(error_count), 64'd2);
      check("r35_wc", 64'(word_count), 64'd6);
      check("r35_bexp", bad_expected, CAP ? 64'd3 : 64'd0);
      check("r35_brcv", bad_received, CAP ? 64'd7 : 64'd0);

      // 64-bit wrap of the expected word
      cycle(1'b1, BASE, 64'h3, 1'b0, 64'd0);
      q = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
      feed(q, nc);
      check("r36_ec", 64'(error_count), 64'd0);
      check("r36_wc", 64'(word_count), 64'd4);

      // throttle N=3: one read in four
      cycle(1'b1, BASE + 13'd1, 64'd3, 1'b0, 64'd0);
      cycle(1'b1, BASE, 64'h3, 1'b0, 64'd0);
      rd_cnt = 0;
      dval = 64'd500;
      for (int i = 0; i < 40; i++) begin
         rd_cnt += int'(fpc_read);
         cycle(1'b0, 13'd0, 64'd0, 1'b1, dval);
         if (m_xfer) dval = dval + 64'd1;
      end
      check("r37_reads", 64'(rd_cnt), 64'd10);
      check("r37_wc", 64'(word_count), 64'd10);
      check("r37_ec", 64'(error_count), 64'd0);

      // clear coincident with a transfer, then reset mid-stream
      cycle(1'b1, BASE + 13'd1, 64'd0, 1'b0, 64'd0);
      cycle(1'b1, BASE, 64'h3, 1'b0, 64'd0);
      q.delete();
      for (int i = 0; i < 5; i++) q.push_back(64'(i));
      feed(q, nc);
      check("pre_clr_read", 64'(fpc_read), 64'd1);
      cycle(1'b1, BASE, 64'h3, 1'b1, 64'd5);
      check("clr_wc", 64'(word_count), 64'd0);
      check("clr_ec", 64'(error_count), 64'd0);
      check("clr_locked", 64'(locked), 64'd0);
      q.delete();
      for (int i = 20; i < 30; i++) q.push_back(64'(i));
      feed(q, nc);
      check("pre_rst_wc", 64'(word_count), 64'd10);
      check("pre_rst_read", 64'(fpc_read), 64'd1);
      pio_write_valid = 1'b0; fpc_valid = 1'b1; fpc_data = 64'd30;
      reset = 1'b1;
      model_reset();
      @(posedge clock);
      @(negedge clock);
      check("rst_read", 64'(fpc_read), 64'd0);
      check("rst_locked", 64'(locked), 64'd0);
      check("rst_wc", 64'(word_count), 64'd0);
      check("rst_ec", 64'(error_count), 64'd0);
      compare_all();
      reset = 1'b0;

      // randomized traffic against the model
      cycle(1'b1, BASE, 64'h1, 1'b0, 64'd0);
      dval = {$urandom, $urandom};
      for (int i = 0; i < 600; i++) begin
         logic        wv, fv;
         logic [12:0] wa;
         logic [63:0] wd, fd;
         int          r;
         wv = ($urandom_range(0, 11) == 0);
         r  = int'($urandom_range(0, 3));
         wa = (r == 0) ? BASE : (r == 1) ? BASE + 13'd1 : (r == 2) ? BASE + 13'd2 : 13'd5;
         wd = {$urandom, $urandom};
         if (r == 0) begin
            wd[0] = ($urandom_range(0, 5) != 0);
            wd[1] = ($urandom_range(0, 3) == 0);
         end
         if (r == 1) wd[3:0] = 4'($urandom_range(0, 3));
         fd = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : dval;
         fv = ($urandom_range(0, 3) != 0);
         cycle(wv, wa, wd, fv, fd);
         if (m_xfer) dval = fd + 64'd1;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
